// File: rtl/bus_if.sv
// External memory bus interface: captures each core cycle, runs it on the external bus with
// wait states, ack handshake and timeout, and returns read bytes through the DI/DR/D3 chain.
module bus_if #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [23:0] AB,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic        ready,
    output logic [7:0]  DI,
    output logic [7:0]  DR,
    output logic [7:0]  D3,
    output logic [23:0] ext_addr,
    output logic        ext_req,
    output logic        ext_we,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    input  logic        ext_ack,
    input  logic        err_clr,
    output logic        bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] WS_INIT = 8'(WAIT_STATES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic       TO_EN   = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [23:0] ext_addr_q, ext_addr_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [7:0]  ext_dout_q, ext_dout_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  dr_q, dr_d;
    logic [7:0]  d3_q, d3_d;
    logic        bus_err_q, bus_err_d;
    logic        timeout;

    // tcnt counts ack-eligible cycles only, so the last one is TIMEOUT-1
    assign timeout = TO_EN && (tcnt_q == TO_LAST) && !ext_ack;
    assign ready   = (state_q == IDLE) || ((wcnt_q == 8'd0) && (ext_ack || timeout));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        ext_addr_d = ext_addr_q;
        ext_req_d  = ext_req_q;
        ext_we_d   = ext_we_q;
        ext_dout_d = ext_dout_q;
        di_d       = di_q;
        dr_d       = dr_q;
        d3_d       = d3_q;
        // clear first so a timeout in the same cycle overrides it
        bus_err_d  = bus_err_q & ~err_clr;

        if (state_q == BUSY) begin
            if (wcnt_q != 8'd0) begin
                wcnt_d = wcnt_q - 8'd1;
            end else if (ready) begin
                if (!ext_we_q) begin
                    d3_d = dr_q;
                    dr_d = di_q;
                    di_d = timeout ? 8'hFF : ext_din;
                end
                if (timeout) begin
                    bus_err_d = 1'b1;
                end
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end

        // back-to-back capture: the next request is taken on the completion edge
        if (ready) begin
            ext_addr_d = AB;
            ext_we_d   = WE;
            ext_dout_d = DO;
            ext_req_d  = 1'b1;
            wcnt_d     = WS_INIT;
            tcnt_d     = 8'd0;
            state_d    = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            wcnt_q     <= 8'd0;
            tcnt_q     <= 8'd0;
            ext_addr_q <= 24'd0;
            ext_req_q  <= 1'b0;
            ext_we_q   <= 1'b0;
            ext_dout_q <= 8'd0;
            di_q       <= 8'd0;
            dr_q       <= 8'd0;
            d3_q       <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            ext_addr_q <= ext_addr_d;
            ext_req_q  <= ext_req_d;
            ext_we_q   <= ext_we_d;
            ext_dout_q <= ext_dout_d;
            di_q       <= di_d;
            dr_q       <= dr_d;
            d3_q       <= d3_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign DI       = di_q;
    assign DR       = dr_q;
    assign D3       = d3_q;
    assign ext_addr = ext_addr_q;
    assign ext_req  = ext_req_q;
    assign ext_we   = ext_we_q;
    assign ext_dout = ext_dout_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_bus_if.sv
// Bench for bus_if: two instances (WS=0/TO=4 and WS=2/TO=16) share stimulus; a per-cycle
// behavioural model tracks each access by its age, and directed points pin literal values.
module tb_bus_if;

    logic        clk = 1'b0;
    logic        RST;
    logic [23:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic [7:0]  ext_din;
    logic        ext_ack;
    logic        err_clr;

    logic        ready_w    [2];
    logic [7:0]  di_w       [2];
    logic [7:0]  dr_w       [2];
    logic [7:0]  d3_w       [2];
    logic [23:0] ext_addr_w [2];
    logic        ext_req_w  [2];
    logic        ext_we_w   [2];
    logic [7:0]  ext_dout_w [2];
    logic        bus_err_w  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_if #(.WAIT_STATES(0), .TIMEOUT(4)) u_a (
        .clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO),
        .ready(ready_w[0]), .DI(di_w[0]), .DR(dr_w[0]), .D3(d3_w[0]),
        .ext_addr(ext_addr_w[0]), .ext_req(ext_req_w[0]), .ext_we(ext_we_w[0]),
        .ext_dout(ext_dout_w[0]), .ext_din(ext_din), .ext_ack(ext_ack),
        .err_clr(err_clr), .bus_err(bus_err_w[0])
    );

    bus_if #(.WAIT_STATES(2), .TIMEOUT(16)) u_b (
        .clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO),
        .ready(ready_w[1]), .DI(di_w[1]), .DR(dr_w[1]), .D3(d3_w[1]),
        .ext_addr(ext_addr_w[1]), .ext_req(ext_req_w[1]), .ext_we(ext_we_w[1]),
        .ext_dout(ext_dout_w[1]), .ext_din(ext_din), .ext_ack(ext_ack),
        .err_clr(err_clr), .bus_err(bus_err_w[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Model: an access is described by its age in BUSY cycles since capture.
    int          ws [2] = '{0, 2};
    int          tmo[2] = '{4, 16};
    bit          started = 1'b0;
    bit          busy  [2];
    int          age   [2];
    bit          m_req [2];
    bit          m_we  [2];
    bit          m_err [2];
    logic [23:0] m_addr[2];
    logic [7:0]  m_dout[2];
    logic [7:0]  m_di  [2];
    logic [7:0]  m_dr  [2];
    logic [7:0]  m_d3  [2];

    function automatic bit m_timeout(input int i);
        return busy[i] && tmo[i] != 0 && age[i] >= ws[i] && (age[i] - ws[i] == tmo[i] - 1) && !ext_ack;
    endfunction

    function automatic bit m_ready(input int i);
        return !busy[i] || (age[i] >= ws[i] && (ext_ack || m_timeout(i)));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                busy[i] = 0; age[i] = 0; m_req[i] = 0; m_we[i] = 0; m_err[i] = 0;
                m_addr[i] = '0; m_dout[i] = '0; m_di[i] = '0; m_dr[i] = '0; m_d3[i] = '0;
            end else begin
                automatic bit r = m_ready(i);
                automatic bit t = m_timeout(i);
                if (busy[i] && r && !m_we[i]) begin
                    m_d3[i] = m_dr[i];
                    m_dr[i] = m_di[i];
                    m_di[i] = t ? 8'hFF : ext_din;
                end
                m_err[i] = (busy[i] && r && t) ? 1'b1 : (err_clr ? 1'b0 : m_err[i]);
                if (r) begin
                    busy[i] = 1; age[i] = 0; m_req[i] = 1;
                    m_addr[i] = AB; m_we[i] = WE; m_dout[i] = DO;
                end else begin
                    age[i]++;
                end
            end
        end
        if (RST) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk("m_ready", i, 32'(ready_w[i]), 32'(m_ready(i)));
                chk("m_chain", i, {8'h0, di_w[i], dr_w[i], d3_w[i]}, {8'h0, m_di[i], m_dr[i], m_d3[i]});
                chk("m_addr", i, 32'(ext_addr_w[i]), 32'(m_addr[i]));
                chk("m_req", i, 32'(ext_req_w[i]), 32'(m_req[i]));
                chk("m_we", i, 32'(ext_we_w[i]), 32'(m_we[i]));
                chk("m_dout", i, 32'(ext_dout_w[i]), 32'(m_dout[i]));
                chk("m_err", i, 32'(bus_err_w[i]), 32'(m_err[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST = 1; AB = '0; WE = 0; DO = '0; ext_din = '0; ext_ack = 0; err_clr = 0;
        tick();
        tick();
        // reset state and first capture
        RST = 0; AB = 24'h001000; ext_ack = 1;
        #1;
        chk("rst_chain", 0, {8'h0, di_w[0], dr_w[0], d3_w[0]}, 32'h0);
        chk("rst_req", 0, 32'(ext_req_w[0]), 32'h0);
        chk("rst_err", 0, 32'(bus_err_w[0]), 32'h0);
        chk("rst_ready_a", 0, 32'(ready_w[0]), 32'h1);
        chk("rst_ready_b", 1, 32'(ready_w[1]), 32'h1);
        $display("txn reset released");
        tick();
        AB = 24'h001001; ext_din = 8'h34;
        #1;
        chk("cap_addr", 0, 32'(ext_addr_w[0]), 32'h001000);
        chk("cap_req", 0, 32'(ext_req_w[0]), 32'h1);
        chk("ws0_ready", 0, 32'(ready_w[0]), 32'h1);
        chk("ws2_ready_c1", 1, 32'(ready_w[1]), 32'h0);
        $display("txn read 0x001000");
        tick();
        AB = 24'h001002; ext_din = 8'h12;
        #1;
        chk("rd1_di", 0, 32'(di_w[0]), 32'h34);
        chk("ws2_ready_c2", 1, 32'(ready_w[1]), 32'h0);
        $display("txn read 0x001001");
        tick();
        AB = 24'hFFFFFA; WE = 1; DO = 8'hA5; ext_din = 8'h56;
        #1;
        chk("ws0_ready3", 0, 32'(ready_w[0]), 32'h1);
        chk("ws2_ready_c3", 1, 32'(ready_w[1]), 32'h1);
        $display("txn read 0x001002");
        tick();
        chk("chain3", 0, {8'h0, di_w[0], dr_w[0], d3_w[0]}, 32'h561234);
        chk("ws2_di", 1, 32'(di_w[1]), 32'h56);
        chk("wr_addr", 0, 32'(ext_addr_w[0]), 32'hFFFFFA);
        chk("wr_we", 0, 32'(ext_we_w[0]), 32'h1);
        chk("wr_dout", 0, 32'(ext_dout_w[0]), 32'hA5);
        chk("wr_addr_b", 1, 32'(ext_addr_w[1]), 32'hFFFFFA);
        AB = 24'h000123; WE = 0; DO = 8'h00; ext_din = 8'h77;
        $display("txn write 0xFFFFFA=0xA5");
        tick();
        chk("wr_hold", 0, {8'h0, di_w[0], dr_w[0], d3_w[0]}, 32'h561234);
        chk("to_addr", 0, 32'(ext_addr_w[0]), 32'h000123);
        // timeout: ack withheld, A forces completion in its 4th eligible cycle
        ext_ack = 0; ext_din = 8'h88;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("to_wait_ready", 0, 32'(ready_w[0]), 32'h0);
            tick();
        end
        AB = 24'h000124;
        #1;
        chk("to_ready", 0, 32'(ready_w[0]), 32'h1);
        tick();
        chk("to_di", 0, 32'(di_w[0]), 32'hFF);
        chk("to_chain", 0, {8'h0, dr_w[0], d3_w[0]}, 32'h5612);
        chk("to_err", 0, 32'(bus_err_w[0]), 32'h1);
        $display("txn timeout read 0x000123");
        err_clr = 1; ext_ack = 1; ext_din = 8'h9A;
        tick();
        chk("err_clr", 0, 32'(bus_err_w[0]), 32'h0);
        chk("rd_after_to", 0, 32'(di_w[0]), 32'h9A);
        chk("ws2_wr_hold", 1, 32'(di_w[1]), 32'h56);
        $display("txn err_clr, read 0x000124");
        // reset during BUSY with an ack present: ack must not load DI
        err_clr = 0; RST = 1; ext_din = 8'hEE;
        tick();
        chk("mid_rst_di", 0, 32'(di_w[0]), 32'h00);
        chk("mid_rst_req", 0, 32'(ext_req_w[0]), 32'h0);
        RST = 0; AB = 24'h00ABCD; ext_din = 8'h00;
        #1;
        chk("mid_rst_ready", 0, 32'(ready_w[0]), 32'h1);
        $display("txn reset mid-busy");
        tick();
        ext_din = 8'h42;
        tick();
        chk("post_rst_rd", 0, 32'(di_w[0]), 32'h42);
        $display("txn read 0x00ABCD");
        for (int c = 0; c < 4; c++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
